pipelined_memory_unit: RTL

//  Load/store unit between the core's execute stage and an Avalon-MM data port. Generalised

---
 rtl/pipelined_memory_unit_if.sv | 22 ++
 rtl/pipelined_memory_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pipelined_memory_unit_if.sv
// pipelined_memory_unit_if: Avalon-MM read/write data port between the load/store unit and memory
interface pipelined_memory_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   host_to_agent;
  logic [DATA_WIDTH-1:0]   agent_to_host;
  logic                    waitrequest;
  logic                    readdatavalid;
  modport master (
    output address, byteenable, read, write, host_to_agent,
    input  agent_to_host, waitrequest, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, host_to_agent,
    output agent_to_host, waitrequest, readdatavalid
  );
endinterface

// File: rtl/pipelined_memory_unit.sv
// pipelined_memory_unit: load/store unit with up to MAX_PENDING in-order pipelined reads on Avalon-MM
module pipelined_memory_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_address,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_zero_extend,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_error,
  pipelined_memory_unit_if.master port
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PW    = MAX_PENDING > 1 ? $clog2(MAX_PENDING) : 1;
  localparam int CW    = $clog2(MAX_PENDING + 1);
  localparam int EW    = OFF_W + 3;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  typedef enum logic [1:0] {IDLE, CMD_READ, CMD_WRITE, DRAIN} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_pending;
  logic [PW-1:0]         r_wp, r_rp;
  logic [EW-1:0]         r_fifo [MAX_PENDING];

  logic [OFF_W-1:0]      w_off, w_head_off;
  logic                  w_mis, w_load, w_acc, w_issue, w_ret, w_head_zx, w_sgn;
  logic [1:0]            w_head_size;
  logic [CW-1:0]         w_next_pend;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [BYTES-1:0]      w_be;
  logic [DATA_WIDTH-1:0] w_wdata, w_sh, w_keep, w_rdata;
  logic [EW-1:0]         w_head;

  assign w_off       = i_req_address[OFF_W-1:0];
  assign w_mis       = (i_req_size == SZ_H && w_off[0]) || (i_req_size == SZ_W && w_off[1:0] != 2'b0);
  assign w_load      = !i_req_write && !w_mis;
  assign w_addr      = i_req_address & ~ADDR_WIDTH'(BYTES - 1);
  assign w_be        = BYTES'(i_req_size == SZ_B ? 4'h1 : i_req_size == SZ_H ? 4'h3 : 4'hF) << w_off;
  assign w_wdata     = i_req_wdata << {w_off, 3'b000};
  assign w_issue     = r_state == CMD_READ && !port.waitrequest;
  assign w_ret       = port.readdatavalid && r_pending != '0;
  assign w_next_pend = r_pending + CW'(w_issue) - CW'(w_ret);
  assign w_acc       = i_req_valid && o_req_ready;

  // Stores and errors only go out with nothing pending, which keeps responses in order
  always_comb begin
    o_req_ready = 1'b0;
    if (!rst)
      o_req_ready = r_state == IDLE ? (r_pending != CW'(MAX_PENDING) && !(r_pending != '0 && !w_load)) :
                    r_state == CMD_READ ? (!port.waitrequest && w_load && w_next_pend < CW'(MAX_PENDING)) :
                    1'b0;
  end

  assign w_head      = r_fifo[r_rp];
  assign w_head_off  = w_head[OFF_W-1:0];
  assign w_head_size = w_head[OFF_W+1:OFF_W];
  assign w_head_zx   = w_head[OFF_W+2];
  assign w_sh        = port.agent_to_host >> {w_head_off, 3'b000};
  assign w_sgn       = !w_head_zx && (w_head_size == SZ_B ? w_sh[7] : w_head_size == SZ_H ? w_sh[15] : w_sh[31]);
  assign w_keep      = ~({DATA_WIDTH{1'b1}} << (w_head_size == SZ_B ? 8 : w_head_size == SZ_H ? 16 : 32));
  assign w_rdata     = (w_sh & w_keep) | (w_sgn ? ~w_keep : '0);

  always_ff @(posedge clk)
    if (w_acc && w_load) r_fifo[r_wp] <= {i_req_zero_extend, i_req_size, w_off};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state            <= IDLE;
      r_pending          <= '0;
      r_wp               <= '0;
      r_rp               <= '0;
      port.read          <= 1'b0;
      port.write         <= 1'b0;
      port.address       <= '0;
      port.byteenable    <= '0;
      port.host_to_agent <= '0;
      o_rsp_valid        <= 1'b0;
      o_rsp_data         <= '0;
      o_rsp_error        <= 1'b0;
    end else begin
      r_pending   <= w_next_pend;
      o_rsp_valid <= w_ret;
      if (w_ret) begin
        o_rsp_data  <= w_rdata;
        o_rsp_error <= 1'b0;
        r_rp        <= r_rp == PW'(MAX_PENDING - 1) ? '0 : r_rp + 1'b1;
      end
      if (w_acc && w_load) r_wp <= r_wp == PW'(MAX_PENDING - 1) ? '0 : r_wp + 1'b1;
      case (r_state)
        IDLE:
          if (w_acc && w_load) begin
            r_state         <= CMD_READ;
            port.read       <= 1'b1;
            port.address    <= w_addr;
            port.byteenable <= w_be;
          end else if (i_req_valid && !w_load && r_pending != '0) begin
            r_state <= DRAIN;
          end else if (w_acc && w_mis) begin
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= '0;
            o_rsp_error <= 1'b1;
          end else if (w_acc) begin
            r_state            <= CMD_WRITE;
            port.write         <= 1'b1;
            port.address       <= w_addr;
            port.byteenable    <= w_be;
            port.host_to_agent <= w_wdata;
          end
        CMD_READ:
          if (!port.waitrequest) begin
            if (w_acc) begin
              port.address    <= w_addr;
              port.byteenable <= w_be;
            end else begin
              port.read <= 1'b0;
              r_state   <= IDLE;
            end
          end
        CMD_WRITE:
          if (!port.waitrequest) begin
            port.write  <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= '0;
            o_rsp_error <= 1'b0;
            r_state     <= IDLE;
          end
        default:
          if (r_pending == '0) r_state <= IDLE;
      endcase
    end

  a_no_stray_rdv: assert property (@(posedge clk) disable iff (rst) !(port.readdatavalid && r_pending == '0));
endmodule
